mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master.sv | 142 ++++++++++++++
 tb/tb_mem_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// ============================================================================
//  Module   : mem_master
//  Purpose  : Burst read/write master for a strobe-driven (mem_en-edge) memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_ONE_A = ADDR_W'(1);
    localparam logic [DATA_W-1:0] C_ONE_D = DATA_W'(1);

    state_t              state_q,    state_d;
    logic                rw_q,       rw_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [ADDR_W-1:0]   len_q,      len_d;
    logic [ADDR_W-1:0]   k_q,        k_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                done_q,     done_d;
    logic                beat_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            k_q        <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            k_q        <= k_d;
            rsp_data_q <= rsp_data_d;
            rsp_addr_q <= rsp_addr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        k_d        = k_q;
        rsp_data_d = rsp_data_q;
        rsp_addr_d = rsp_addr_q;
        done_d     = 1'b0;
        beat_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    len_d   = cmd_len;
                    k_d     = '0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                if (rw_q) begin
                    rsp_data_d = mem_rdata;
                    rsp_addr_d = addr_q;
                    state_d    = RESP;
                end else begin
                    beat_adv = 1'b1;
                end
            end
            RESP: beat_adv = rsp_ready;
            default: state_d = IDLE;
        endcase

        // Per-beat write data is cmd_wdata + k, kept as a running increment.
        if (beat_adv) begin
            if (k_q == len_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                k_d     = k_q + C_ONE_A;
                addr_d  = addr_q + C_ONE_A;
                wdata_d = wdata_q + C_ONE_D;
                state_d = SETUP;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == STROBE);
    assign mem_rw    = rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_master.sv
// ============================================================================
//  Module   : tb_mem_master
//  Purpose  : Table-driven self-checking bench for mem_master with a strobe memory.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_master;

    localparam int AW = 6;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_rw;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          busy, done;
    logic          mem_en, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .busy(busy), .done(done),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Edge-triggered memory: writes on the rising edge of mem_en.
    logic [DW-1:0] mem [0:63];
    logic          mem_init = 1'b0;
    always @(posedge mem_en or posedge mem_init) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = DW'(i * 5 + 3);
        end else if (!mem_rw) begin
            mem[mem_addr] = mem_wdata;
        end
    end
    assign mem_rdata = mem_en ? mem[mem_addr] : {DW{1'bz}};

    logic [DW-1:0] shadow [0:63];
    int  checks = 0;
    int  fails  = 0;
    logic prev_en = 1'b0;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] len;
        int            stall;
        int            exp_done;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mem_en) chk("mem_en_back_to_back", int'(prev_en), 0);
        prev_en = mem_en;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_en"},    int'(mem_en),    0);
        chk({tag, "_mem_rw"},    int'(mem_rw),    0);
        chk({tag, "_mem_addr"},  int'(mem_addr),  0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_data"},  int'(rsp_data),  0);
        chk({tag, "_rsp_addr"},  int'(rsp_addr),  0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    endtask

    // Issues one burst from the current negedge and follows it to done.
    task automatic run_burst(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [AW-1:0] len, input int stall, input int exp_done);
        int c, beat, st, idx;
        bit fin;
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = wd; cmd_len = len;
        rsp_ready = (stall == 0);
        tick();
        cmd_valid = 1'b0;
        c = 1; beat = 0; st = stall; fin = 1'b0;
        while (!fin && c < 200) begin
            idx = (int'(a) + beat) % 64;
            if (done) begin
                fin = 1'b1;
                chk("done_cycle", c, exp_done);
                chk("beat_count", beat, int'(len) + 1);
                chk("busy_after_done", int'(busy), 0);
            end else begin
                chk("busy_in_burst", int'(busy), 1);
                if (mem_en) begin
                    chk("strobe_addr", int'(mem_addr), idx);
                    chk("strobe_rw", int'(mem_rw), int'(rw));
                    if (!rw) begin
                        chk("strobe_wdata", int'(mem_wdata), (int'(wd) + beat) % 16);
                        shadow[idx] = DW'(int'(wd) + beat);
                        beat++;
                    end
                end
                if (rsp_valid) begin
                    chk("rsp_data", int'(rsp_data), int'(shadow[idx]));
                    chk("rsp_addr", int'(rsp_addr), idx);
                    if (st > 0) begin
                        rsp_ready = 1'b0;
                        st--;
                    end else begin
                        rsp_ready = 1'b1;
                        beat++;
                    end
                end
            end
            if (!fin) begin
                tick();
                c++;
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
    endtask

    int  c, beat;
    bit  fin;

    initial begin
        tbl[0] = '{1'b0,  6'd5,  4'd9, 6'd0, 0,  3};
        tbl[1] = '{1'b1,  6'd5,  4'd0, 6'd0, 0,  4};
        tbl[2] = '{1'b0, 6'd62, 4'd14, 6'd3, 0,  9};
        tbl[3] = '{1'b1, 6'd62,  4'd0, 6'd3, 0, 13};
        tbl[4] = '{1'b1, 6'd62,  4'd0, 6'd1, 5, 12};
        tbl[5] = '{1'b0, 6'd20, 4'd15, 6'd2, 0,  7};
        tbl[6] = '{1'b1, 6'd20,  4'd0, 6'd2, 0, 10};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = DW'(i * 5 + 3);
        #1 mem_init = 1'b1;
        #1 mem_init = 1'b0;
        #1 chk_reset("rst_initial");
        tick(); tick();
        chk_reset("rst_held");
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++)
            run_burst(tbl[v].rw, tbl[v].addr, tbl[v].wdata, tbl[v].len, tbl[v].stall, tbl[v].exp_done);

        // Reset during the SETUP of the third beat of an 8-beat write.
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 6'd40; cmd_wdata = 4'd3; cmd_len = 6'd7;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_pre_addr", int'(mem_addr), 42);
        shadow[40] = 4'd3;
        shadow[41] = 4'd4;
        rst_n = 1'b0;
        #1 chk_reset("rst_async");
        tick();
        chk_reset("rst_mid");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_en", int'(mem_en), 0);
            chk("abort_no_done", int'(done), 0);
        end
        run_burst(1'b1, 6'd40, 4'd0, 6'd2, 0, 10);

        // cmd_valid held through a burst: the second command waits for IDLE.
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 6'd10; cmd_wdata = 4'd2; cmd_len = 6'd1;
        tick();
        cmd_addr = 6'd30; cmd_wdata = 4'd7; cmd_len = 6'd0;
        c = 1; beat = 0; fin = 1'b0;
        while (!fin && c < 50) begin
            if (done) begin
                fin = 1'b1;
                chk("held_done_cycle", c, 5);
            end else begin
                chk("held_no_ready", int'(cmd_ready), 0);
                if (mem_en) begin
                    chk("held_a_addr", int'(mem_addr), 10 + beat);
                    chk("held_a_wdata", int'(mem_wdata), 2 + beat);
                    beat++;
                end
            end
            tick();
            c++;
        end
        if (!fin) chk("held_timeout", 0, 1);
        chk("held_b_busy", int'(busy), 1);
        chk("held_b_setup_en", int'(mem_en), 0);
        chk("held_b_addr", int'(mem_addr), 30);
        cmd_valid = 1'b0;
        tick();
        chk("held_b_strobe", int'(mem_en), 1);
        chk("held_b_wdata", int'(mem_wdata), 7);
        tick();
        chk("held_b_done", int'(done), 1);
        shadow[10] = 4'd2;
        shadow[11] = 4'd3;
        shadow[30] = 4'd7;
        run_burst(1'b1, 6'd10, 4'd0, 6'd1, 0, 7);
        run_burst(1'b1, 6'd30, 4'd0, 6'd0, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
